// File: rtl/dual_path_mismatch_monitor.sv
// Equivalence checker for two redundantly computed result buses: waits a
// programmable settle window after each stimulus change, then compares them.
module dual_path_mismatch_monitor #(
   parameter int W      = 1,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_stim_chg,
   input  logic [W-1:0]     i_res_a,
   input  logic [W-1:0]     i_res_b,
   output logic             o_busy,
   output logic             o_check_done,
   output logic             o_match,
   output logic             o_mismatch_sticky,
   output logic [CNT_W-1:0] o_check_cnt,
   output logic [CNT_W-1:0] o_miss_cnt,
   output logic [W-1:0]     o_first_a,
   output logic [W-1:0]     o_first_b
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CHECK
   } state_t;

   localparam logic [3:0]       SETTLE_L  = 4'(SETTLE);
   localparam state_t           ARM_STATE = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic             r_checkDone;
   logic             r_match;
   logic             r_sticky;
   logic [CNT_W-1:0] r_checkCnt;
   logic [CNT_W-1:0] r_missCnt;
   logic [W-1:0]     r_firstA;
   logic [W-1:0]     r_firstB;

   logic w_equal;

   assign w_equal = (i_res_a == i_res_b);

   // Any stimulus change restarts the settle window, even while a comparison
   // is in progress; the comparison on that edge still counts.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_checkDone <= 1'b0;
         r_match     <= 1'b0;
         r_sticky    <= 1'b0;
         r_checkCnt  <= '0;
         r_missCnt   <= '0;
         r_firstA    <= '0;
         r_firstB    <= '0;
      end else if (i_clear) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_checkDone <= 1'b0;
         r_match     <= 1'b0;
         r_sticky    <= 1'b0;
         r_checkCnt  <= '0;
         r_missCnt   <= '0;
         r_firstA    <= '0;
         r_firstB    <= '0;
      end else begin
         r_checkDone <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_stim_chg) begin
                  r_state <= ARM_STATE;
                  r_cnt   <= SETTLE_L;
               end
            end
            ST_WAIT: begin
               if (i_stim_chg) begin
                  r_state <= ARM_STATE;
                  r_cnt   <= SETTLE_L;
               end else if (r_cnt == 4'd1) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_CHECK: begin
               r_checkDone <= 1'b1;
               r_match     <= w_equal;
               if (r_checkCnt != CNT_MAX) begin
                  r_checkCnt <= r_checkCnt + 1'b1;
               end
               if (!w_equal) begin
                  r_sticky <= 1'b1;
                  if (r_missCnt != CNT_MAX) begin
                     r_missCnt <= r_missCnt + 1'b1;
                  end
                  if (!r_sticky) begin
                     r_firstA <= i_res_a;
                     r_firstB <= i_res_b;
                  end
               end
               if (i_stim_chg) begin
                  r_state <= ARM_STATE;
                  r_cnt   <= SETTLE_L;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy            = (r_state != ST_IDLE);
   assign o_check_done      = r_checkDone;
   assign o_match           = r_match;
   assign o_mismatch_sticky = r_sticky;
   assign o_check_cnt       = r_checkCnt;
   assign o_miss_cnt        = r_missCnt;
   assign o_first_a         = r_firstA;
   assign o_first_b         = r_firstB;

endmodule

// File: tb/tb_dual_path_mismatch_monitor.sv
// Bench for dual_path_mismatch_monitor: three instances (settle 2, 0, 3; the
// last with 2-bit counters) share stimulus and are compared to a deadline model.
module tb_dual_path_mismatch_monitor;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       stimChg;
   logic [3:0] resA;
   logic [3:0] resB;

   logic        obsBusy[3];
   logic        obsDone[3];
   logic        obsMatch[3];
   logic        obsSticky[3];
   logic [15:0] obsCheckCnt[3];
   logic [15:0] obsMissCnt[3];
   logic [3:0]  obsFirstA[3];
   logic [3:0]  obsFirstB[3];
   logic [1:0]  smallCheckCnt;
   logic [1:0]  smallMissCnt;

   int checks = 0;
   int errors = 0;
   int edgeNo = 0;

   int settleOf[3] = '{2, 0, 3};
   int cntMaxOf[3] = '{65535, 65535, 3};

   int mPending[3];
   int mDeadline[3];
   int mDone[3];
   int mMatch[3];
   int mSticky[3];
   int mCheckCnt[3];
   int mMissCnt[3];
   int mFirstA[3];
   int mFirstB[3];

   dual_path_mismatch_monitor #(.W(4), .SETTLE(2), .CNT_W(16)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_stim_chg(stimChg),
      .i_res_a(resA), .i_res_b(resB),
      .o_busy(obsBusy[0]), .o_check_done(obsDone[0]), .o_match(obsMatch[0]),
      .o_mismatch_sticky(obsSticky[0]), .o_check_cnt(obsCheckCnt[0]),
      .o_miss_cnt(obsMissCnt[0]), .o_first_a(obsFirstA[0]), .o_first_b(obsFirstB[0])
   );

   dual_path_mismatch_monitor #(.W(4), .SETTLE(0), .CNT_W(16)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_stim_chg(stimChg),
      .i_res_a(resA), .i_res_b(resB),
      .o_busy(obsBusy[1]), .o_check_done(obsDone[1]), .o_match(obsMatch[1]),
      .o_mismatch_sticky(obsSticky[1]), .o_check_cnt(obsCheckCnt[1]),
      .o_miss_cnt(obsMissCnt[1]), .o_first_a(obsFirstA[1]), .o_first_b(obsFirstB[1])
   );

   dual_path_mismatch_monitor #(.W(4), .SETTLE(3), .CNT_W(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_stim_chg(stimChg),
      .i_res_a(resA), .i_res_b(resB),
      .o_busy(obsBusy[2]), .o_check_done(obsDone[2]), .o_match(obsMatch[2]),
      .o_mismatch_sticky(obsSticky[2]), .o_check_cnt(smallCheckCnt),
      .o_miss_cnt(smallMissCnt), .o_first_a(obsFirstA[2]), .o_first_b(obsFirstB[2])
   );

   assign obsCheckCnt[2] = {14'd0, smallCheckCnt};
   assign obsMissCnt[2]  = {14'd0, smallMissCnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edgeNo);
      end
   endtask

   task automatic modelZero();
      for (int k = 0; k < 3; k++) begin
         mPending[k]  = 0;
         mDeadline[k] = 0;
         mDone[k]     = 0;
         mMatch[k]    = 0;
         mSticky[k]   = 0;
         mCheckCnt[k] = 0;
         mMissCnt[k]  = 0;
         mFirstA[k]   = 0;
         mFirstB[k]   = 0;
      end
   endtask

   // Reference: each stimulus change schedules a comparison SETTLE+1 edges
   // later, replacing any earlier schedule.
   task automatic modelEdge(input int stim, input int clr, input int a, input int b);
      int compared;
      edgeNo++;
      for (int k = 0; k < 3; k++) begin
         if (clr != 0) begin
            mPending[k] = 0;
            mDone[k]    = 0;
            mMatch[k]   = 0;
            mSticky[k]  = 0;
            mCheckCnt[k] = 0;
            mMissCnt[k] = 0;
            mFirstA[k]  = 0;
            mFirstB[k]  = 0;
         end else begin
            compared = (mPending[k] != 0 && mDeadline[k] == edgeNo) ? 1 : 0;
            mDone[k] = compared;
            if (compared != 0) begin
               mMatch[k] = (a == b) ? 1 : 0;
               mCheckCnt[k] = (mCheckCnt[k] + 1 > cntMaxOf[k]) ? cntMaxOf[k] : mCheckCnt[k] + 1;
               if (a != b) begin
                  mMissCnt[k] = (mMissCnt[k] + 1 > cntMaxOf[k]) ? cntMaxOf[k] : mMissCnt[k] + 1;
                  if (mSticky[k] == 0) begin
                     mFirstA[k] = a;
                     mFirstB[k] = b;
                  end
                  mSticky[k] = 1;
               end
            end
            if (stim != 0) begin
               mPending[k]  = 1;
               mDeadline[k] = edgeNo + settleOf[k] + 1;
            end else if (compared != 0) begin
               mPending[k] = 0;
            end
         end
      end
   endtask

   task automatic checkAll();
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("d%0d_busy", k),   32'(obsBusy[k]),     32'(mPending[k]));
         checkOutput($sformatf("d%0d_done", k),   32'(obsDone[k]),     32'(mDone[k]));
         checkOutput($sformatf("d%0d_match", k),  32'(obsMatch[k]),    32'(mMatch[k]));
         checkOutput($sformatf("d%0d_sticky", k), 32'(obsSticky[k]),   32'(mSticky[k]));
         checkOutput($sformatf("d%0d_chkcnt", k), 32'(obsCheckCnt[k]), 32'(mCheckCnt[k]));
         checkOutput($sformatf("d%0d_miscnt", k), 32'(obsMissCnt[k]),  32'(mMissCnt[k]));
         checkOutput($sformatf("d%0d_firsta", k), 32'(obsFirstA[k]),   32'(mFirstA[k]));
         checkOutput($sformatf("d%0d_firstb", k), 32'(obsFirstB[k]),   32'(mFirstB[k]));
      end
   endtask

   // Drive one cycle of inputs away from the edge, then check just after it.
   task automatic applyStimulus(input int stim, input int clr, input int a, input int b);
      @(negedge clk);
      stimChg = 1'(stim);
      clear   = 1'(clr);
      resA    = 4'(a);
      resB    = 4'(b);
      @(posedge clk);
      modelEdge(stim, clr, a, b);
      #1;
      checkAll();
   endtask

   task automatic idleCycles(input int n, input int a, input int b);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, a, b);
      end
   endtask

   // Reset asserted between edges must take effect without waiting for a clock.
   task automatic asyncReset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      modelZero();
      checkAll();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int a;
      int b;
      rst     = 1'b1;
      clear   = 1'b0;
      stimChg = 1'b0;
      resA    = 4'd0;
      resB    = 4'd0;
      modelZero();
      repeat (2) @(posedge clk);
      #1;
      checkAll();
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(1, 0, 5, 5);
      idleCycles(6, 5, 5);
      checkOutput("plan_match_chkcnt", 32'(obsCheckCnt[0]), 32'd1);
      checkOutput("plan_match_match", 32'(obsMatch[0]), 32'd1);

      applyStimulus(1, 0, 3, 7);
      idleCycles(6, 3, 7);
      applyStimulus(1, 0, 1, 2);
      idleCycles(6, 1, 2);
      checkOutput("plan_capture_firsta", 32'(obsFirstA[0]), 32'h3);
      checkOutput("plan_capture_firstb", 32'(obsFirstB[0]), 32'h7);
      checkOutput("plan_capture_miscnt", 32'(obsMissCnt[0]), 32'd2);
      checkOutput("plan_capture_match", 32'(obsMatch[0]), 32'd0);

      applyStimulus(1, 0, 9, 9);
      applyStimulus(1, 0, 9, 9);
      idleCycles(6, 9, 9);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, i, i + 8);
         idleCycles(5, i, i + 8);
      end
      checkOutput("plan_sat_miscnt", 32'(obsMissCnt[2]), 32'd3);
      checkOutput("plan_sat_chkcnt", 32'(obsCheckCnt[2]), 32'd3);

      applyStimulus(1, 0, 4, 6);
      applyStimulus(0, 0, 4, 6);
      applyStimulus(1, 1, 4, 6);
      checkOutput("plan_clear_busy", 32'(obsBusy[0]), 32'd0);
      checkOutput("plan_clear_miscnt", 32'(obsMissCnt[0]), 32'd0);
      idleCycles(6, 4, 6);

      applyStimulus(1, 0, 2, 3);
      applyStimulus(0, 0, 2, 3);
      asyncReset();
      idleCycles(6, 2, 3);

      for (int i = 0; i < 3000; i++) begin
         a = int'($urandom_range(15, 0));
         b = ($urandom_range(2, 0) == 0) ? int'($urandom_range(15, 0)) : a;
         applyStimulus(($urandom_range(3, 0) == 0) ? 1 : 0,
                       ($urandom_range(49, 0) == 0) ? 1 : 0, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
